// File: rtl/alu_sched_pkg.sv
// Shared constants for the two-requester ALU scheduler: width, opcodes, FSM states.
// The MUL iteration count is tied to the operand width.
package alu_pkg;

    localparam int W         = 16;
    localparam int MUL_ITERS = 16;
    localparam int CNT_W     = $clog2(MUL_ITERS);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two front-end ports and the scheduler.
// master = front-end/consumer side, slave = scheduler side.
interface alu_sched_if;
    import alu_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_cout;
    logic         rsp_err;
    logic         busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy
    );

endinterface

// File: rtl/alu_sched_core.sv
// Combinational 16-bit ALU: ripple adder shared by ADD and SUB, plus bitwise ops.
// MUL is not computed here; the scheduler iterates it through the ADD path.
module alu_core
    import alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         illegal
);

    logic [W-1:0] b_eff;
    logic [W:0]   carry;
    logic [W-1:0] sum;

    always_comb begin
        // SUB is a + ~b + 1, so cout doubles as the no-borrow flag
        b_eff    = (op == OP_SUB) ? ~b : b;
        carry    = '0;
        carry[0] = (op == OP_SUB);
        sum      = '0;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end

    always_comb begin
        s       = '0;
        cout    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                s    = sum;
                cout = carry[W];
            end
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            OP_XOR:  s = a ^ b;
            OP_MUL:  s = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between two requesters; 2-edge latency, 17 for MUL.
// Requests are accepted only in IDLE; the response is held until rsp_ready.
module alu_sched
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu_sched_if.slave bus
);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             id_q, id_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_err_q, rsp_err_d;

    logic             in_idle;
    logic             gnt1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic [2:0]       sel_op;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     core_a;
    logic [W-1:0]     core_b;
    logic [2:0]       core_op;
    logic [W-1:0]     core_s;
    logic             core_cout;
    logic             core_illegal;
    logic [W-1:0]     acc_next;

    // Grant goes to the lone valid requester, or away from last_grant on contention
    assign in_idle = (state_q == ST_IDLE) && !rst;
    assign gnt1    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign ready0  = in_idle && bus.req0_valid && !gnt1;
    assign ready1  = in_idle && bus.req1_valid && gnt1;
    assign accept  = ready0 || ready1;

    assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;
    assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;

    assign core_a  = (state_q == ST_MUL) ? acc_q   : a_q;
    assign core_b  = (state_q == ST_MUL) ? mcand_q : b_q;
    assign core_op = (state_q == ST_MUL) ? OP_ADD  : op_q;

    alu_core u_core (
        .a       (core_a),
        .b       (core_b),
        .op      (core_op),
        .s       (core_s),
        .cout    (core_cout),
        .illegal (core_illegal)
    );

    assign acc_next = mplier_q[0] ? core_s : acc_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    if (sel_op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = sel_a;
                        mplier_d = sel_b;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                rsp_id_d   = id_q;
                rsp_data_d = core_illegal ? '0 : core_s;
                rsp_cout_d = core_illegal ? 1'b0 : core_cout;
                rsp_err_d  = core_illegal;
                state_d    = ST_RESP;
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                    rsp_id_d   = id_q;
                    rsp_data_d = acc_next;
                    rsp_cout_d = 1'b0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                // Result is already registered; valid rises one edge after entry
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed cases with literal expectations, then random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_alu_sched;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sched_if bus();

    alu_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // {err, cout, data} from the arithmetic definition of each opcode
    function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        logic [31:0] p;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; return {1'b0, t[16], t[15:0]}; end
            3'd1: return {1'b0, (a >= b), 16'(a - b)};
            3'd2: return {2'b00, a & b};
            3'd3: return {2'b00, a | b};
            3'd4: return {2'b00, a ^ b};
            3'd5: begin p = 32'(a) * 32'(b); return {2'b00, p[15:0]}; end
            default: return {1'b1, 1'b0, 16'h0000};
        endcase
    endfunction

    // Transaction-level model state, valid for the current cycle
    bit          m_busy = 0;
    int          m_age  = 0;
    int          m_lat  = 0;
    logic        m_last = 1'b1;
    logic        m_id   = 1'b0;
    logic [17:0] m_exp  = '0;
    logic        g1, e_r0, e_r1, e_rv;
    logic [2:0]  n_op;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {9'd0, bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                                bus.rsp_cout, bus.rsp_err, bus.busy, bus.rsp_data}, 32'd0);
            m_busy = 0;
            m_age  = 0;
            m_last = 1'b1;
        end else begin
            g1   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
            e_r0 = !m_busy && bus.req0_valid && !g1;
            e_r1 = !m_busy && bus.req1_valid && g1;
            e_rv = m_busy && (m_age >= m_lat);
            chk("m_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'({e_r0, e_r1}));
            chk("m_valid_busy", 32'({bus.rsp_valid, bus.busy}), 32'({e_rv, m_busy}));
            if (e_rv)
                chk("m_rsp", {13'd0, bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_data},
                             {13'd0, m_id, m_exp});
            if (m_busy) begin
                if (e_rv && bus.rsp_ready) m_busy = 0;
                else                       m_age++;
            end else if (e_r0 || e_r1) begin
                n_op   = g1 ? bus.req1_op : bus.req0_op;
                m_exp  = g1 ? model(bus.req1_op, bus.req1_a, bus.req1_b)
                            : model(bus.req0_op, bus.req0_a, bus.req0_b);
                m_lat  = (n_op == 3'd5) ? 17 : 2;
                m_id   = g1;
                m_last = g1;
                m_age  = 0;
                m_busy = 1;
            end
        end
    end

    task automatic drive(input int port, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Returns #1 after the accepting edge with that port's valid dropped
    task automatic wait_accept(input int port);
        logic r;
        r = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = (port == 0) ? bus.req0_ready : bus.req1_ready;
            @(posedge clk);
            if (r) break;
        end
        #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
        chk("accept", 32'(r), 32'd1);
    endtask

    task automatic send(input int port, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        drive(port, op, a, b);
        wait_accept(port);
    endtask

    // Counts edges after the call until rsp_valid is seen at a negedge
    task automatic wait_rsp(output int edges, output logic any_rdy);
        edges   = 0;
        any_rdy = 1'b0;
        while (edges < 60) begin
            @(negedge clk);
            any_rdy = any_rdy | bus.req0_ready | bus.req1_ready;
            if (bus.rsp_valid) break;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic expect_rsp(input string name, input int lat, input logic id,
                              input logic [15:0] data, input logic cout, input logic err);
        int   e;
        logic ar;
        wait_rsp(e, ar);
        if (lat >= 0) begin
            chk({name, "_lat"}, 32'(e), 32'(lat));
            chk({name, "_no_ready"}, 32'(ar), 32'd0);
        end
        chk({name, "_rsp"}, {13'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_err, bus.rsp_data},
                            {13'd0, 1'b1, id, cout, err, data});
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;

        chk("model_pin_sub", 32'(model(3'd1, 16'h0003, 16'h0005)), 32'h0FFFE);
        chk("model_pin_mul", 32'(model(3'd5, 16'h0123, 16'h0045)), 32'h04E6F);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(0, OP_ADD, 16'h7FFF, 16'h0001);
        expect_rsp("add", 2, 1'b0, 16'h8000, 1'b0, 1'b0);
        send(1, OP_SUB, 16'h0003, 16'h0005);
        expect_rsp("sub_lt", 2, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(1, OP_SUB, 16'h0005, 16'h0003);
        expect_rsp("sub_ge", 2, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Both requesters valid continuously: grants must alternate
        @(posedge clk);
        #1;
        drive(0, OP_ADD, 16'h0001, 16'h0001);
        drive(1, OP_XOR, 16'hF0F0, 16'hFFFF);
        for (int i = 0; i < 6; i++) begin
            expect_rsp("alt", -1, 1'(i % 2), (i % 2 == 1) ? 16'h0F0F : 16'h0002, 1'b0, 1'b0);
            @(posedge clk);
        end
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // MUL with requester 1 waiting the whole time
        @(posedge clk);
        #1;
        drive(1, OP_ADD, 16'h0001, 16'h0001);
        drive(0, OP_MUL, 16'h0123, 16'h0045);
        wait_accept(0);
        expect_rsp("mul", 17, 1'b0, 16'h4E6F, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;

        // Back-pressure: response held, no new grant
        bus.rsp_ready = 1'b0;
        send(0, OP_ADD, 16'h0001, 16'h0002);
        expect_rsp("bp", 2, 1'b0, 16'h0003, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(0, 3'b111, 16'h0005, 16'h0006);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {13'd0, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_data},
                           {13'd0, 1'b1, 1'b0, 1'b0, 16'h0003});
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_accept(0);
        expect_rsp("illegal", 2, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset during MUL iteration 8 with both requesters waiting
        send(0, OP_ADD, 16'h1111, 16'h2222);
        expect_rsp("pre_rst", 2, 1'b0, 16'h3333, 1'b0, 1'b0);
        send(0, OP_MUL, 16'h1234, 16'h5678);
        repeat (8) @(posedge clk);
        #1;
        drive(0, OP_ADD, 16'h0010, 16'h0020);
        drive(1, OP_ADD, 16'h0100, 16'h0200);
        rst = 1'b1;
        #1;
        chk("rst_mid_mul", {9'd0, bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                            bus.rsp_cout, bus.rsp_err, bus.busy, bus.rsp_data}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        expect_rsp("post_rst", 2, 1'b0, 16'h0030, 1'b0, 1'b0);

        // Random traffic; the per-cycle model compare does the checking
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_op    = 3'($urandom_range(0, 7));
            bus.req1_op    = 3'($urandom_range(0, 7));
            bus.req0_a     = 16'($urandom);
            bus.req1_a     = 16'($urandom);
            bus.req0_b     = ($urandom_range(0, 3) == 0) ? bus.req0_a : 16'($urandom);
            bus.req1_b     = ($urandom_range(0, 3) == 0) ? bus.req1_a : 16'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drained_idle", 32'({bus.busy, bus.rsp_valid}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
